// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Two requesters (ALU, LSU) share the port; a pending scoreboard drives the decode stall.
module rf_wb_arbiter #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_a_valid,
  input  logic [4:0]      i_a_rd,
  input  logic [XLEN-1:0] i_a_data,
  output logic            o_a_ready,
  input  logic            i_b_valid,
  input  logic [4:0]      i_b_rd,
  input  logic [XLEN-1:0] i_b_data,
  output logic            o_b_ready,
  input  logic            i_issue_valid,
  input  logic [4:0]      i_issue_rd,
  input  logic [4:0]      i_rs1,
  input  logic [4:0]      i_rs2,
  output logic            o_stall,
  output logic            o_wr,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_write_data
);

  localparam bit FIXED = (PRIO_MODE != 0);

  logic            last_b;
  logic            grant_a, grant_b, xfer;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [NREG-1:0] pending, pending_nxt, set_mask, clr_mask;

  // A wins a conflict when priority is fixed or B was granted last.
  always_comb begin
    grant_a  = i_a_valid & (~i_b_valid | FIXED | last_b);
    grant_b  = i_b_valid & ~grant_a;
    xfer     = grant_a | grant_b;
    sel_rd   = grant_a ? i_a_rd   : i_b_rd;
    sel_data = grant_a ? i_a_data : i_b_data;
  end

  assign o_a_ready = grant_a;
  assign o_b_ready = grant_b;

  // Set after clear so a same-cycle reissue keeps the register pending.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (i_issue_valid && i_issue_rd != 5'd0) set_mask[i_issue_rd] = 1'b1;
    if (xfer && sel_rd != 5'd0)              clr_mask[sel_rd]     = 1'b1;
    pending_nxt    = (pending & ~clr_mask) | set_mask;
    pending_nxt[0] = 1'b0;
  end

  assign o_stall = pending[i_rs1] | pending[i_rs2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_wr         <= 1'b0;
      o_rd         <= 5'd0;
      o_write_data <= '0;
      pending      <= '0;
      last_b       <= 1'b1;
    end else begin
      o_wr    <= xfer && (sel_rd != 5'd0);
      pending <= pending_nxt;
      if (xfer) begin
        o_rd         <= sel_rd;
        o_write_data <= sel_data;
        last_b       <= grant_b;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: round-robin and fixed-priority instances share stimulus.
module tb_rf_wb_arbiter;

  logic        clk, rst;
  logic        a_valid, b_valid, issue_valid;
  logic [4:0]  a_rd, b_rd, issue_rd, rs1, rs2;
  logic [31:0] a_data, b_data;

  logic        a_ready0, b_ready0, stall0, wr0;
  logic [4:0]  rd0;
  logic [31:0] wdata0;
  logic        a_ready1, b_ready1, stall1, wr1;
  logic [4:0]  rd1;
  logic [31:0] wdata1;

  int total = 0;
  int passed = 0;

  rf_wb_arbiter #(.XLEN(32), .NREG(32), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .rst(rst),
    .i_a_valid(a_valid), .i_a_rd(a_rd), .i_a_data(a_data), .o_a_ready(a_ready0),
    .i_b_valid(b_valid), .i_b_rd(b_rd), .i_b_data(b_data), .o_b_ready(b_ready0),
    .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
    .i_rs1(rs1), .i_rs2(rs2), .o_stall(stall0),
    .o_wr(wr0), .o_rd(rd0), .o_write_data(wdata0)
  );

  rf_wb_arbiter #(.XLEN(32), .NREG(32), .PRIO_MODE(1)) dut_fp (
    .clk(clk), .rst(rst),
    .i_a_valid(a_valid), .i_a_rd(a_rd), .i_a_data(a_data), .o_a_ready(a_ready1),
    .i_b_valid(b_valid), .i_b_rd(b_rd), .i_b_data(b_data), .o_b_ready(b_ready1),
    .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
    .i_rs1(rs1), .i_rs2(rs2), .o_stall(stall1),
    .o_wr(wr1), .o_rd(rd1), .o_write_data(wdata1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_rd = 0; a_data = 0;
    b_valid = 0; b_rd = 0; b_data = 0;
    issue_valid = 0; issue_rd = 0;
    rs1 = 0; rs2 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #3;
    total++; if (wr0 !== 1'b0) $display("FAIL reset_wr got %b want 0", wr0); else passed++;
    total++; if (rd0 !== 5'd0) $display("FAIL reset_rd got %0d want 0", rd0); else passed++;
    total++; if (wdata0 !== 32'h0) $display("FAIL reset_data got %h want 0", wdata0); else passed++;
    for (int r = 0; r < 32; r++) begin
      rs1 = r[4:0]; rs2 = r[4:0];
      #1;
      total++; if (stall0 !== 1'b0) $display("FAIL reset_pending rs=%0d got %b want 0", r, stall0); else passed++;
    end
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single();
    a_valid = 1; a_rd = 5; a_data = 32'hABCDEFFF;
    #1;
    total++; if (a_ready0 !== 1'b1) $display("FAIL single_a_ready got %b want 1", a_ready0); else passed++;
    total++; if (b_ready0 !== 1'b0) $display("FAIL single_b_ready got %b want 0", b_ready0); else passed++;
    step();
    a_valid = 0;
    total++; if (wr0 !== 1'b1) $display("FAIL single_wr got %b want 1", wr0); else passed++;
    total++; if (rd0 !== 5'd5) $display("FAIL single_rd got %0d want 5", rd0); else passed++;
    total++; if (wdata0 !== 32'hABCDEFFF) $display("FAIL single_data got %h want abcdefff", wdata0); else passed++;
    step();
    total++; if (wr0 !== 1'b0) $display("FAIL single_wr_after got %b want 0", wr0); else passed++;
    total++; if (rd0 !== 5'd5) $display("FAIL single_rd_hold got %0d want 5", rd0); else passed++;
    total++; if (wdata0 !== 32'hABCDEFFF) $display("FAIL single_data_hold got %h want abcdefff", wdata0); else passed++;
  endtask

  task automatic test_round_robin();
    do_reset();
    a_valid = 1; a_rd = 3; a_data = 32'h11;
    b_valid = 1; b_rd = 7; b_data = 32'h22;
    #1;
    total++; if (a_ready0 !== 1'b1 || b_ready0 !== 1'b0)
      $display("FAIL rr1_grant got a=%b b=%b want a=1 b=0", a_ready0, b_ready0); else passed++;
    step();
    a_valid = 0;
    #1;
    total++; if (wr0 !== 1'b1 || rd0 !== 5'd3 || wdata0 !== 32'h11)
      $display("FAIL rr1_write_a got wr=%b rd=%0d data=%h want 1/3/11", wr0, rd0, wdata0); else passed++;
    total++; if (b_ready0 !== 1'b1) $display("FAIL rr1_b_ready got %b want 1", b_ready0); else passed++;
    step();
    b_valid = 0;
    total++; if (wr0 !== 1'b1 || rd0 !== 5'd7 || wdata0 !== 32'h22)
      $display("FAIL rr1_write_b got wr=%b rd=%0d data=%h want 1/7/22", wr0, rd0, wdata0); else passed++;
    // last grant is B now, so A should win again
    a_valid = 1; a_rd = 4; a_data = 32'h44;
    b_valid = 1; b_rd = 8; b_data = 32'h88;
    #1;
    total++; if (a_ready0 !== 1'b1 || b_ready0 !== 1'b0)
      $display("FAIL rr2_grant got a=%b b=%b want a=1 b=0", a_ready0, b_ready0); else passed++;
    step();
    a_valid = 0;
    total++; if (wr0 !== 1'b1 || rd0 !== 5'd4 || wdata0 !== 32'h44)
      $display("FAIL rr2_write_a got wr=%b rd=%0d data=%h want 1/4/44", wr0, rd0, wdata0); else passed++;
    step();
    b_valid = 0;
    total++; if (wr0 !== 1'b1 || rd0 !== 5'd8 || wdata0 !== 32'h88)
      $display("FAIL rr2_write_b got wr=%b rd=%0d data=%h want 1/8/88", wr0, rd0, wdata0); else passed++;
    step();
  endtask

  task automatic test_fixed_prio();
    do_reset();
    a_valid = 1; a_rd = 3; a_data = 32'h11;
    b_valid = 1; b_rd = 7; b_data = 32'h22;
    #1;
    total++; if (a_ready1 !== 1'b1 || b_ready1 !== 1'b0)
      $display("FAIL fp_c1_grant got a=%b b=%b want a=1 b=0", a_ready1, b_ready1); else passed++;
    step();
    a_rd = 4; a_data = 32'h33;
    #1;
    total++; if (rd1 !== 5'd3 || wdata1 !== 32'h11) $display("FAIL fp_c1_write got rd=%0d data=%h want 3/11", rd1, wdata1); else passed++;
    total++; if (a_ready1 !== 1'b1 || b_ready1 !== 1'b0)
      $display("FAIL fp_c2_grant got a=%b b=%b want a=1 b=0", a_ready1, b_ready1); else passed++;
    total++; if (b_ready0 !== 1'b1) $display("FAIL rr_alternate got b_ready=%b want 1", b_ready0); else passed++;
    step();
    a_rd = 5; a_data = 32'h55;
    #1;
    total++; if (rd1 !== 5'd4 || b_ready1 !== 1'b0) $display("FAIL fp_c3 got rd=%0d b_ready=%b want 4/0", rd1, b_ready1); else passed++;
    step();
    a_valid = 0;
    #1;
    total++; if (wr1 !== 1'b1 || rd1 !== 5'd5 || wdata1 !== 32'h55)
      $display("FAIL fp_c3_write got wr=%b rd=%0d data=%h want 1/5/55", wr1, rd1, wdata1); else passed++;
    total++; if (b_ready1 !== 1'b1) $display("FAIL fp_c4_b_ready got %b want 1", b_ready1); else passed++;
    step();
    b_valid = 0;
    total++; if (wr1 !== 1'b1 || rd1 !== 5'd7 || wdata1 !== 32'h22)
      $display("FAIL fp_write_b got wr=%b rd=%0d data=%h want 1/7/22", wr1, rd1, wdata1); else passed++;
    step();
  endtask

  task automatic test_scoreboard();
    do_reset();
    issue_valid = 1; issue_rd = 9;
    step();
    issue_valid = 0; rs1 = 9; rs2 = 0;
    #1;
    total++; if (stall0 !== 1'b1) $display("FAIL sb_stall_set got %b want 1", stall0); else passed++;
    a_valid = 1; a_rd = 9; a_data = 32'h99;
    #1;
    total++; if (stall0 !== 1'b1) $display("FAIL sb_stall_before_write got %b want 1", stall0); else passed++;
    step();
    a_valid = 0;
    total++; if (wr0 !== 1'b1 || rd0 !== 5'd9) $display("FAIL sb_write got wr=%b rd=%0d want 1/9", wr0, rd0); else passed++;
    total++; if (stall0 !== 1'b0) $display("FAIL sb_stall_cleared got %b want 0", stall0); else passed++;
    // reissue and writeback of the same register in one cycle
    issue_valid = 1; issue_rd = 9;
    step();
    a_valid = 1; a_rd = 9; a_data = 32'h98;
    step();
    issue_valid = 0; a_valid = 0;
    total++; if (wr0 !== 1'b1 || rd0 !== 5'd9) $display("FAIL sb_same_write got wr=%b rd=%0d want 1/9", wr0, rd0); else passed++;
    total++; if (stall0 !== 1'b1) $display("FAIL sb_set_wins got %b want 1", stall0); else passed++;
    // independent set of rd 10 and clear of rd 9
    issue_valid = 1; issue_rd = 10;
    a_valid = 1; a_rd = 9; a_data = 32'h97;
    step();
    issue_valid = 0; a_valid = 0;
    rs1 = 9; rs2 = 0;
    #1;
    total++; if (stall0 !== 1'b0) $display("FAIL sb_indep_clear got %b want 0", stall0); else passed++;
    rs1 = 0; rs2 = 10;
    #1;
    total++; if (stall0 !== 1'b1) $display("FAIL sb_indep_set got %b want 1", stall0); else passed++;
    rs1 = 0; rs2 = 0;
  endtask

  task automatic test_x0();
    do_reset();
    a_valid = 1; a_rd = 0; a_data = 32'hFFFFFFFF;
    #1;
    total++; if (a_ready0 !== 1'b1) $display("FAIL x0_ready got %b want 1", a_ready0); else passed++;
    step();
    a_valid = 0;
    total++; if (wr0 !== 1'b0) $display("FAIL x0_wr got %b want 0", wr0); else passed++;
    issue_valid = 1; issue_rd = 0;
    step();
    issue_valid = 0; rs1 = 0; rs2 = 0;
    #1;
    total++; if (stall0 !== 1'b0) $display("FAIL x0_stall got %b want 0", stall0); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_valid = 1; a_rd = 13; a_data = 32'h1313;
    issue_valid = 1; issue_rd = 12;
    step();
    a_valid = 0; issue_valid = 0;
    b_valid = 1; b_rd = 12; b_data = 32'h1212;
    rs1 = 12; rs2 = 0;
    #1;
    total++; if (wr0 !== 1'b1 || stall0 !== 1'b1 || b_ready0 !== 1'b1)
      $display("FAIL rm_pre got wr=%b stall=%b b_ready=%b want 1/1/1", wr0, stall0, b_ready0); else passed++;
    #5;
    rst = 1'b1;
    #1;
    total++; if (wr0 !== 1'b0 || rd0 !== 5'd0 || wdata0 !== 32'h0)
      $display("FAIL rm_outputs got wr=%b rd=%0d data=%h want 0/0/0", wr0, rd0, wdata0); else passed++;
    total++; if (stall0 !== 1'b0) $display("FAIL rm_pending got %b want 0", stall0); else passed++;
    b_valid = 0;
    #4;
    rst = 1'b0;
    step();
    total++; if (wr0 !== 1'b0) $display("FAIL rm_dropped got wr=%b want 0", wr0); else passed++;
    a_valid = 1; a_rd = 1; a_data = 32'h1;
    b_valid = 1; b_rd = 2; b_data = 32'h2;
    #1;
    total++; if (a_ready0 !== 1'b1 || b_ready0 !== 1'b0)
      $display("FAIL rm_first_conflict got a=%b b=%b want a=1 b=0", a_ready0, b_ready0); else passed++;
    step();
    a_valid = 0; b_valid = 0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_prio();
    test_scoreboard();
    test_x0();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
